pipe_skid_stage: RTL and testbench
==================================

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 96, payload width in bits.
REQ-002 The block SHALL expose parameter SKID, default 1: 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
REQ-003 The block SHALL expose parameter CNT_W, default 16, stall counter width.
REQ-004 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  stage enable; 0 = freeze all state; both sides show no transfer.
- flush  in  1  discards all held entries.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  downstream entry present.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  head payload.
- occupancy  out  2  entries held: 0, 1 or 2.
- stall_cnt  out  CNT_W  saturating count of back-pressured cycles.
- stall_cnt_clr  in  1  synchronous clear of stall_cnt.

Function
REQ-005 Accept SHALL be in_valid && in_ready; pop SHALL be out_valid && out_ready; both are qualified by en.
REQ-006 out_valid SHALL be (occupancy != 0) && en && !rst; in_ready SHALL be forced 0 while en=0 or rst=1.
REQ-007 With SKID=1, in_ready SHALL be (occupancy != 2) && en, with no combinational path from out_ready.
REQ-008 With SKID=1, state transitions SHALL be: EMPTY+accept -> ONE (head<=in_data); ONE+accept+pop -> ONE (head<=in_data); ONE+accept only -> FULL (skid<=in_data); ONE+pop only -> EMPTY; FULL+pop -> ONE (head<=skid); otherwise hold.
REQ-009 With SKID=0, in_ready SHALL be (!out_valid || out_ready) && en; occupancy never exceeds 1; accept+pop in the same cycle replaces head.
REQ-010 Latency SHALL be exactly 1 cycle from accept into an empty stage to out_valid=1; sustained throughput SHALL be 1 entry/cycle for both SKID values when out_ready=1.
REQ-011 Ordering SHALL be strict FIFO; no entry is duplicated or dropped except by flush or rst.
REQ-012 out_data SHALL be 0 whenever occupancy=0; the skid register SHALL be 0 when not occupied.
REQ-013 flush SHALL override en. The next state SHALL be EMPTY with head and skid zeroed. An accept in the flush cycle SHALL be discarded; a pop in the flush cycle is complete from the downstream view.
REQ-014 en=0 SHALL hold occupancy, head, skid and stall_cnt unchanged, except when flush or rst is asserted.
REQ-015 stall_cnt SHALL increment by 1 on each cycle with out_valid && !out_ready, saturate at 2^CNT_W-1, and ignore flush.
REQ-016 stall_cnt_clr SHALL zero stall_cnt on the next edge and SHALL take priority over a simultaneous increment.

Reset
REQ-017 On rst=1 at a rising edge, the stage SHALL set occupancy 0, head 0, skid 0 and stall_cnt 0, taking priority over flush, en and handshakes.
REQ-018 Reset SHALL have these output values: out_data 0, out_valid 0, in_ready 0.
REQ-019 Reset asserted mid-operation SHALL discard all held entries without emitting them.

Structure
REQ-020 Shared package pipe_pkg SHALL hold the occupancy enum (EMPTY=0, ONE=1, FULL=2) and the default DATA_W/CNT_W constants.
REQ-021 The saturating stall counter SHALL be one sub-module, pipe_sat_counter, parametrised by CNT_W, with increment and clear inputs.
REQ-022 SKID selection SHALL be a generate-time choice with no runtime mode input.

Verification
REQ-023 Streaming: SKID=1, out_ready=1, 8 back-to-back entries 0x1..0x8 -> out_data 0x1..0x8 on 8 consecutive cycles, one cycle after each accept; stall_cnt=0.
REQ-024 Skid fill: SKID=1, accept 0xA, then out_ready=0 while presenting 0xB -> occupancy=2 and in_ready=0. On out_ready=1: 0xA then 0xB, occupancy returns to 0.
REQ-025 Flush: occupancy=2 and flush=1 with in_valid=1 carrying 0xC -> next cycle occupancy=0, out_data=0, out_valid=0; 0xC never appears.
REQ-026 Enable freeze: occupancy=1 holding 0x5, en=0 for 4 cycles with out_ready=1 -> out_valid=0, in_ready=0, state kept. After en=1, 0x5 pops.
REQ-027 Counter: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15. stall_cnt_clr=1 together with back-pressure -> stall_cnt=0 next cycle.
REQ-028 Reset mid-stream: SKID=0, rst=1 while occupancy=1 -> all outputs 0 next cycle; with rst=0 and out_ready=1, in_ready=1 again.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid stage.
//   occ_t      : occupancy encoding (EMPTY=0, ONE=1, FULL=2)
//   DATA_W_DEF : default payload width
//   CNT_W_DEF  : default stall counter width
package pipe_pkg;

    localparam int unsigned DATA_W_DEF = 96;
    localparam int unsigned CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, zeroes the count
//   inc   : add one this cycle (ignored once all ones)
//   clr   : zero the count next edge, wins over inc
//   count : current value
module pipe_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline stage, either a two-entry skid buffer (SKID=1,
// registered in_ready) or a single register (SKID=0, in_ready depends
// combinationally on out_ready). Also counts back-pressured cycles.
//   clk, rst       : clock and synchronous active-high reset
//   en             : stage enable; 0 freezes state and blocks both handshakes
//   flush          : drop all held entries (overrides en)
//   in_valid/in_ready/in_data    : upstream handshake and payload
//   out_valid/out_ready/out_data : downstream handshake and head payload
//   occupancy      : number of held entries (0..2)
//   stall_cnt      : saturating count of out_valid && !out_ready cycles
//   stall_cnt_clr  : synchronous clear of stall_cnt
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_cnt_clr
);

    occ_t              state, state_nx;
    logic [DATA_W-1:0] head, head_nx;
    logic [DATA_W-1:0] skid, skid_nx;
    logic              active;
    logic              accept;
    logic              pop;

    assign active    = en && !rst;
    assign out_valid = (state != EMPTY) && active;
    assign occupancy = state;
    // head is kept zero while empty, so only reset needs masking here
    assign out_data  = rst ? '0 : head;

    generate
        if (SKID != 0) begin : g_skid
            // depends only on registered state: no path from out_ready
            assign in_ready = (state != FULL) && active;
        end else begin : g_single
            assign in_ready = (!out_valid || out_ready) && active;
        end
    endgenerate

    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;

    always_comb begin
        state_nx = state;
        head_nx  = head;
        skid_nx  = skid;
        if (flush) begin
            state_nx = EMPTY;
            head_nx  = '0;
            skid_nx  = '0;
        end else if (en) begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_nx = ONE;
                        head_nx  = in_data;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        head_nx = in_data;
                    end else if (accept && (SKID != 0)) begin
                        state_nx = FULL;
                        skid_nx  = in_data;
                    end else if (pop) begin
                        state_nx = EMPTY;
                        head_nx  = '0;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_nx = ONE;
                        head_nx  = skid;
                        skid_nx  = '0;
                    end
                end
                default: begin
                    state_nx = EMPTY;
                    head_nx  = '0;
                    skid_nx  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            head  <= '0;
            skid  <= '0;
        end else begin
            state <= state_nx;
            head  <= head_nx;
            skid  <= skid_nx;
        end
    end

    // clear is gated by en so a frozen stage keeps its count
    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_valid && !out_ready),
        .clr   (stall_cnt_clr && en),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_skid_stage.sv
module tb_pipe_skid_stage;

    logic        clk;
    logic        rst, en, flush, in_valid, out_ready, clr;
    logic [95:0] in_data;

    // instance a: SKID=1 CNT_W=16, b: SKID=0 CNT_W=16, c: SKID=1 CNT_W=4
    logic        ir_a, ov_a, ir_b, ov_b, ir_c, ov_c;
    logic [95:0] od_a, od_b, od_c;
    logic [1:0]  occ_a, occ_b, occ_c;
    logic [15:0] sc_a, sc_b;
    logic [3:0]  sc_c;

    int errors = 0;
    int checks = 0;

    // reference model: plain FIFO contents and a counter per instance
    logic [95:0] mbuf [3][2];
    int          mcnt [3];
    int unsigned msc  [3];
    int unsigned mmax [3] = '{65535, 65535, 15};
    int          mskid[3] = '{1, 0, 1};

    typedef struct {
        logic       rst, en, flush, iv;
        logic [7:0] din;
        logic       ordy;
        logic [1:0] e_occ;
        logic       e_ov, e_ir;
        logic [7:0] e_od;
    } vec_t;
    vec_t tbl[$];

    pipe_skid_stage #(.DATA_W(96), .SKID(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .in_valid(in_valid), .in_ready(ir_a), .in_data(in_data),
        .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a),
        .occupancy(occ_a), .stall_cnt(sc_a), .stall_cnt_clr(clr));

    pipe_skid_stage #(.DATA_W(96), .SKID(0), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .in_valid(in_valid), .in_ready(ir_b), .in_data(in_data),
        .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b),
        .occupancy(occ_b), .stall_cnt(sc_b), .stall_cnt_clr(clr));

    pipe_skid_stage #(.DATA_W(96), .SKID(1), .CNT_W(4)) dut_c (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .in_valid(in_valid), .in_ready(ir_c), .in_data(in_data),
        .out_valid(ov_c), .out_ready(out_ready), .out_data(od_c),
        .occupancy(occ_c), .stall_cnt(sc_c), .stall_cnt_clr(clr));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_ov(input int k);
        return (mcnt[k] > 0) && en && !rst;
    endfunction

    function automatic logic m_ir(input int k);
        if (mskid[k] != 0) return (mcnt[k] < 2) && en && !rst;
        return ((mcnt[k] == 0) || out_ready) && en && !rst;
    endfunction

    task automatic chk_inst(input int k, input string nm, input logic ov, input logic ir,
                            input logic [95:0] od, input logic [1:0] occ, input logic [15:0] sc);
        logic [95:0] e_od;
        e_od = (rst || mcnt[k] == 0) ? 96'h0 : mbuf[k][0];
        chk({nm, ".out_valid"}, {95'h0, ov}, {95'h0, m_ov(k)});
        chk({nm, ".in_ready"},  {95'h0, ir}, {95'h0, m_ir(k)});
        chk({nm, ".out_data"},  od, e_od);
        chk({nm, ".occupancy"}, {94'h0, occ}, 96'(mcnt[k]));
        chk({nm, ".stall_cnt"}, {80'h0, sc}, 96'(msc[k]));
    endtask

    task automatic model_update();
        for (int k = 0; k < 3; k++) begin
            logic ov, ir, pop, acc;
            ov  = m_ov(k);
            ir  = m_ir(k);
            pop = ov && out_ready;
            acc = in_valid && ir;
            if (rst) begin
                mcnt[k] = 0;
                msc[k]  = 0;
            end else begin
                if (clr && en) msc[k] = 0;
                else if (ov && !out_ready && msc[k] < mmax[k]) msc[k] = msc[k] + 1;
                if (flush) begin
                    mcnt[k] = 0;
                end else if (en) begin
                    if (pop) begin
                        mbuf[k][0] = mbuf[k][1];
                        mcnt[k]    = mcnt[k] - 1;
                    end
                    if (acc) begin
                        mbuf[k][mcnt[k]] = in_data;
                        mcnt[k]          = mcnt[k] + 1;
                    end
                end
            end
        end
    endtask

    // called at the falling edge with inputs already driven
    task automatic step();
        #1;
        chk_inst(0, "a", ov_a, ir_a, od_a, occ_a, sc_a);
        chk_inst(1, "b", ov_b, ir_b, od_b, occ_b, sc_b);
        chk_inst(2, "c", ov_c, ir_c, od_c, occ_c, {12'h0, sc_c});
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic drive(input logic r, input logic e, input logic f, input logic iv,
                         input logic [95:0] d, input logic ordy, input logic c);
        rst = r; en = e; flush = f; in_valid = iv; in_data = d; out_ready = ordy; clr = c;
    endtask

    task automatic add(input logic r, input logic e, input logic f, input logic iv,
                       input logic [7:0] d, input logic ordy, input logic [1:0] occ,
                       input logic ov, input logic ir, input logic [7:0] od);
        vec_t v;
        v.rst = r; v.en = e; v.flush = f; v.iv = iv; v.din = d; v.ordy = ordy;
        v.e_occ = occ; v.e_ov = ov; v.e_ir = ir; v.e_od = od;
        tbl.push_back(v);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            mcnt[k] = 0; msc[k] = 0; mbuf[k][0] = '0; mbuf[k][1] = '0;
        end
        drive(1, 1, 0, 0, '0, 0, 0);
        @(negedge clk);
        step();
        step();

        // rst en fl iv din ordy | occ ov ir od   (expected before the edge)
        add(0,1,0,1,8'h0A,0, 2'd0,0,1,8'h00); // skid fill
        add(0,1,0,1,8'h0B,0, 2'd1,1,1,8'h0A);
        add(0,1,0,1,8'h0D,0, 2'd2,1,0,8'h0A);
        add(0,1,0,0,8'h00,1, 2'd2,1,0,8'h0A);
        add(0,1,0,0,8'h00,1, 2'd1,1,1,8'h0B);
        add(0,1,0,0,8'h00,1, 2'd0,0,1,8'h00);
        add(0,1,0,1,8'h01,0, 2'd0,0,1,8'h00); // flush while full
        add(0,1,0,1,8'h02,0, 2'd1,1,1,8'h01);
        add(0,1,1,1,8'h0C,0, 2'd2,1,0,8'h01);
        add(0,1,0,0,8'h00,0, 2'd0,0,1,8'h00);
        add(0,1,0,1,8'h05,0, 2'd0,0,1,8'h00); // enable freeze
        add(0,0,0,1,8'h09,1, 2'd1,0,0,8'h05);
        add(0,0,0,1,8'h09,1, 2'd1,0,0,8'h05);
        add(0,0,0,1,8'h09,1, 2'd1,0,0,8'h05);
        add(0,0,0,1,8'h09,1, 2'd1,0,0,8'h05);
        add(0,1,0,0,8'h00,1, 2'd1,1,1,8'h05);
        add(0,1,0,0,8'h00,1, 2'd0,0,1,8'h00);
        add(0,1,0,1,8'h06,1, 2'd0,0,1,8'h00); // accept+pop, then flush with pop
        add(0,1,0,1,8'h07,1, 2'd1,1,1,8'h06);
        add(0,1,1,1,8'h08,1, 2'd1,1,1,8'h07);
        add(0,1,0,0,8'h00,1, 2'd0,0,1,8'h00);
        add(0,1,0,1,8'h03,0, 2'd0,0,1,8'h00); // reset while holding
        add(1,1,0,1,8'h04,0, 2'd1,0,0,8'h00);
        add(0,1,0,0,8'h00,0, 2'd0,0,1,8'h00);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].en, tbl[i].flush, tbl[i].iv, {88'h0, tbl[i].din}, tbl[i].ordy, 0);
            #1;
            chk("tbl.occupancy", {94'h0, occ_a}, {94'h0, tbl[i].e_occ});
            chk("tbl.out_valid", {95'h0, ov_a}, {95'h0, tbl[i].e_ov});
            chk("tbl.in_ready",  {95'h0, ir_a}, {95'h0, tbl[i].e_ir});
            chk("tbl.out_data",  od_a, {88'h0, tbl[i].e_od});
            step();
        end

        // streaming: 8 back-to-back entries emerge one cycle after each accept
        drive(0, 1, 1, 0, '0, 1, 1);
        step();
        for (int i = 1; i <= 9; i++) begin
            drive(0, 1, 0, (i <= 8), 96'(i), 1, 0);
            #1;
            if (i >= 2) begin
                chk("stream.a.out_data", od_a, 96'(i - 1));
                chk("stream.b.out_data", od_b, 96'(i - 1));
            end
            step();
        end
        chk("stream.stall_cnt", {80'h0, sc_a}, 96'h0);

        // counter saturation on the 4-bit instance, then clear under back-pressure
        drive(1, 1, 0, 0, '0, 0, 0);
        step();
        drive(0, 1, 0, 1, 96'h11, 0, 0);
        step();
        drive(0, 1, 0, 0, '0, 0, 0);
        for (int i = 0; i < 20; i++) step();
        chk("sat.c.stall_cnt", {92'h0, sc_c}, 96'd15);
        chk("sat.a.stall_cnt", {80'h0, sc_a}, 96'd20);
        drive(0, 1, 0, 0, '0, 0, 1);
        step();
        drive(0, 1, 0, 0, '0, 0, 0);
        #1;
        chk("clr.c.stall_cnt", {92'h0, sc_c}, 96'd0);
        chk("clr.a.stall_cnt", {80'h0, sc_a}, 96'd0);

        // reset mid-stream on the single-register instance
        drive(0, 1, 1, 0, '0, 1, 0);
        step();
        drive(0, 1, 0, 1, 96'h77, 0, 0);
        step();
        drive(1, 1, 0, 0, '0, 0, 0);
        step();
        drive(0, 1, 0, 0, '0, 1, 0);
        #1;
        chk("rstmid.b.out_valid", {95'h0, ov_b}, 96'h0);
        chk("rstmid.b.out_data",  od_b, 96'h0);
        chk("rstmid.b.occupancy", {94'h0, occ_b}, 96'h0);
        chk("rstmid.b.in_ready",  {95'h0, ir_b}, 96'h1);
        step();

        // randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 99) < 85),
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 99) < 70),
                  {$urandom, $urandom, $urandom}, ($urandom_range(0, 99) < 60),
                  ($urandom_range(0, 29) == 0));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
